// File: rtl/mmul_sequencer.sv
// Index sequencer for C = A*B: walks (i, j, k) with k fastest, presents one MAC op
// per accept, and flags each finished C element and the end of the pass.
module mmul_sequencer #(
  parameter int RA = 2,
  parameter int CA = 2,
  parameter int CB = 2,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          mac_ready,
  output logic          mac_valid,
  output logic [IW-1:0] i_idx,
  output logic [IW-1:0] j_idx,
  output logic [IW-1:0] k_idx,
  output logic          acc_clr,
  output logic          wb_valid,
  output logic [IW-1:0] wb_i,
  output logic [IW-1:0] wb_j,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IW-1:0] I_LAST = IW'(RA - 1);
  localparam logic [IW-1:0] K_LAST = IW'(CA - 1);
  localparam logic [IW-1:0] J_LAST = IW'(CB - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [IW-1:0] wb_i_q, wb_i_d, wb_j_q, wb_j_d;
  logic          wb_valid_q, wb_valid_d;
  logic          accept;

  assign accept = (state_q == RUN) && mac_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_i_q     <= '0;
      wb_j_q     <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wb_valid_q <= wb_valid_d;
      wb_i_q     <= wb_i_d;
      wb_j_q     <= wb_j_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    wb_valid_d = 1'b0;
    wb_i_d     = wb_i_q;
    wb_j_d     = wb_j_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (k_q != K_LAST) begin
            k_d = k_q + IW'(1);
          end else begin
            // Last inner-product term: the element is final once this op lands.
            wb_valid_d = 1'b1;
            wb_i_d     = i_q;
            wb_j_d     = j_q;
            k_d        = '0;
            if (j_q != J_LAST) begin
              j_d = j_q + IW'(1);
            end else begin
              j_d = '0;
              if (i_q != I_LAST) begin
                i_d = i_q + IW'(1);
              end else begin
                i_d     = '0;
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Cancel wins over start and over a same-cycle accept.
    if (abort) begin
      state_d    = IDLE;
      i_d        = '0;
      j_d        = '0;
      k_d        = '0;
      wb_valid_d = 1'b0;
      wb_i_d     = '0;
      wb_j_d     = '0;
    end
  end

  assign mac_valid = (state_q == RUN);
  assign acc_clr   = (state_q == RUN) && (k_q == '0);
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign i_idx     = i_q;
  assign j_idx     = j_q;
  assign k_idx     = k_q;
  assign wb_valid  = wb_valid_q;
  assign wb_i      = wb_i_q;
  assign wb_j      = wb_j_q;

endmodule

// File: tb/tb_mmul_sequencer.sv
// Directed bench for mmul_sequencer: a 2x3x2 instance for pass/stall/abort/reset
// scenarios and a 1x1x1 instance for the degenerate pass with start held high.
module tb_mmul_sequencer;

  localparam int IW = 8;
  localparam int R0 = 2;
  localparam int C0 = 3;
  localparam int B0 = 2;
  localparam int N0 = R0 * C0 * B0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
  logic          mac_valid0, acc_clr0, wb_valid0, busy0, done0;
  logic [IW-1:0] i_idx0, j_idx0, k_idx0, wb_i0, wb_j0;

  logic          start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
  logic          mac_valid1, acc_clr1, wb_valid1, busy1, done1;
  logic [IW-1:0] i_idx1, j_idx1, k_idx1, wb_i1, wb_j1;

  int total = 0;
  int bad   = 0;

  mmul_sequencer #(.RA(R0), .CA(C0), .CB(B0), .IW(IW)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .mac_ready(ready0),
    .mac_valid(mac_valid0), .i_idx(i_idx0), .j_idx(j_idx0), .k_idx(k_idx0),
    .acc_clr(acc_clr0), .wb_valid(wb_valid0), .wb_i(wb_i0), .wb_j(wb_j0),
    .busy(busy0), .done(done0)
  );

  mmul_sequencer #(.RA(1), .CA(1), .CB(1), .IW(IW)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mac_ready(ready1),
    .mac_valid(mac_valid1), .i_idx(i_idx1), .j_idx(j_idx1), .k_idx(k_idx1),
    .acc_clr(acc_clr1), .wb_valid(wb_valid1), .wb_i(wb_i1), .wb_j(wb_j1),
    .busy(busy1), .done(done1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1);
  end

  // One full pass on u0 with an optional stall of stall_len cycles at op stall_op.
  task automatic run_pass0(input int stall_op, input int stall_len, input string tag);
    int n, e, stalls, wbn, post, done_e;
    logic          exp_wb;
    logic [IW-1:0] ewi, ewj, ei, ej, ek;
    logic [3:0]    st, exp_st;
    n = 0; e = 0; stalls = 0; wbn = 0; post = 0; done_e = -1;
    exp_wb = 1'b0; ewi = '0; ewj = '0;
    ready0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    while (post < 3 && e < 60) begin
      total++;
      if (wb_valid0 !== exp_wb || (exp_wb && (wb_i0 !== ewi || wb_j0 !== ewj))) begin
        bad++;
        $display("FAIL %s wb cyc=%0d: actual v=%b (%0d,%0d) required v=%b (%0d,%0d)",
                 tag, e, wb_valid0, wb_i0, wb_j0, exp_wb, ewi, ewj);
      end
      if (wb_valid0 === 1'b1) wbn++;
      if (done0 === 1'b1 && done_e < 0) done_e = e;
      st = {mac_valid0, acc_clr0, busy0, done0};
      if (n < N0) begin
        ei = IW'(n / (C0 * B0));
        ej = IW'((n / C0) % B0);
        ek = IW'(n % C0);
        exp_st = {1'b1, (ek == '0), 1'b1, 1'b0};
        total++;
        if (st !== exp_st || i_idx0 !== ei || j_idx0 !== ej || k_idx0 !== ek) begin
          bad++;
          $display("FAIL %s op cyc=%0d: actual st=%b (%0d,%0d,%0d) required st=%b (%0d,%0d,%0d)",
                   tag, e, st, i_idx0, j_idx0, k_idx0, exp_st, ei, ej, ek);
        end
        if (n == stall_op && stalls < stall_len) begin
          ready0 = 1'b0;
          stalls++;
        end else begin
          ready0 = 1'b1;
        end
        exp_wb = ready0 && (ek == IW'(C0 - 1));
        ewi = ei;
        ewj = ej;
        if (ready0) n++;
      end else begin
        case (post)
          0:       exp_st = 4'b0010;
          1:       exp_st = 4'b0001;
          default: exp_st = 4'b0000;
        endcase
        total++;
        if (st !== exp_st) begin
          bad++;
          $display("FAIL %s tail cyc=%0d: actual st=%b required st=%b", tag, e, st, exp_st);
        end
        exp_wb = 1'b0;
        post++;
      end
      @(posedge clk); #1;
      e++;
    end
    ready0 = 1'b1;
    total++;
    if (done_e !== N0 + 1 + stall_len) begin
      bad++;
      $display("FAIL %s done_cycle: actual=%0d required=%0d", tag, done_e, N0 + 1 + stall_len);
    end
    total++;
    if (wbn !== R0 * B0) begin
      bad++;
      $display("FAIL %s wb_count: actual=%0d required=%0d", tag, wbn, R0 * B0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({mac_valid0, acc_clr0, wb_valid0, busy0, done0, i_idx0, j_idx0, k_idx0, wb_i0, wb_j0} !== '0) begin
      bad++;
      $display("FAIL reset_u0: actual mv=%b ac=%b wb=%b busy=%b done=%b idx=(%0d,%0d,%0d) wb=(%0d,%0d) required all 0",
               mac_valid0, acc_clr0, wb_valid0, busy0, done0, i_idx0, j_idx0, k_idx0, wb_i0, wb_j0);
    end
    total++;
    if ({mac_valid1, acc_clr1, wb_valid1, busy1, done1, i_idx1, j_idx1, k_idx1, wb_i1, wb_j1} !== '0) begin
      bad++;
      $display("FAIL reset_u1: actual mv=%b ac=%b wb=%b busy=%b done=%b required all 0",
               mac_valid1, acc_clr1, wb_valid1, busy1, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({mac_valid0, busy0, done0} !== 3'b000) begin
      bad++;
      $display("FAIL idle_no_start: actual mv/busy/done=%b required 000", {mac_valid0, busy0, done0});
    end
  endtask

  task automatic test_nominal();
    run_pass0(-1, 0, "nominal");
  endtask

  task automatic test_stall();
    // Op (0,1,1) is op index 4.
    run_pass0(4, 3, "stall");
  endtask

  task automatic test_abort();
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    total++;
    if ({mac_valid0, busy0} !== 2'b00) begin
      bad++;
      $display("FAIL abort_over_start: actual mv/busy=%b required 00", {mac_valid0, busy0});
    end
    start0 = 1'b1;
    ready0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    total++;
    if (i_idx0 !== 8'd1 || j_idx0 !== 8'd0 || k_idx0 !== 8'd1 || mac_valid0 !== 1'b1) begin
      bad++;
      $display("FAIL abort_at_op: actual mv=%b (%0d,%0d,%0d) required mv=1 (1,0,1)",
               mac_valid0, i_idx0, j_idx0, k_idx0);
    end
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    total++;
    if ({mac_valid0, acc_clr0, busy0, done0, wb_valid0} !== 5'b0 ||
        {i_idx0, j_idx0, k_idx0} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: actual mv=%b ac=%b busy=%b done=%b wb=%b idx=(%0d,%0d,%0d) required all 0",
               mac_valid0, acc_clr0, busy0, done0, wb_valid0, i_idx0, j_idx0, k_idx0);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++;
      if ({mac_valid0, busy0, done0, wb_valid0} !== 4'b0000) begin
        bad++;
        $display("FAIL abort_quiet cyc=%0d: actual mv/busy/done/wb=%b required 0000",
                 c, {mac_valid0, busy0, done0, wb_valid0});
      end
    end
    run_pass0(-1, 0, "after_abort");
  endtask

  task automatic test_reset_mid();
    start0 = 1'b1;
    ready0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mac_valid0, acc_clr0, wb_valid0, busy0, done0, i_idx0, j_idx0, k_idx0, wb_i0, wb_j0} !== '0) begin
      bad++;
      $display("FAIL async_reset: actual mv=%b ac=%b wb=%b busy=%b done=%b idx=(%0d,%0d,%0d) required all 0",
               mac_valid0, acc_clr0, wb_valid0, busy0, done0, i_idx0, j_idx0, k_idx0);
    end
    #2;
    rst_n = 1'b1;
    run_pass0(-1, 0, "after_reset");
  endtask

  task automatic test_unit_pass();
    logic [4:0] st;
    start1 = 1'b1;
    @(posedge clk); #1;
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b11100 || {i_idx1, j_idx1, k_idx1} !== '0) begin
      bad++;
      $display("FAIL unit_run: actual st=%b idx=(%0d,%0d,%0d) required st=11100 (0,0,0)",
               st, i_idx1, j_idx1, k_idx1);
    end
    @(posedge clk); #1;
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b00101 || wb_i1 !== 8'd0 || wb_j1 !== 8'd0) begin
      bad++;
      $display("FAIL unit_drain: actual st=%b wb=(%0d,%0d) required st=00101 (0,0)", st, wb_i1, wb_j1);
    end
    @(posedge clk); #1;
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b00010) begin
      bad++;
      $display("FAIL unit_done: actual st=%b required st=00010", st);
    end
    @(posedge clk); #1;
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b00000) begin
      bad++;
      $display("FAIL unit_idle_gap: actual st=%b required st=00000", st);
    end
    @(posedge clk); #1;
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b11100) begin
      bad++;
      $display("FAIL unit_restart: actual st=%b required st=11100", st);
    end
    start1 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    st = {mac_valid1, acc_clr1, busy1, done1, wb_valid1};
    total++;
    if (st !== 5'b00000) begin
      bad++;
      $display("FAIL unit_final_idle: actual st=%b required st=00000", st);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_reset_mid();
    test_unit_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
